// File: rtl/fb_pkg.sv
// -----------------------------------------------------------------------------
// fb_pkg
// Shared definitions for the frame-buffer arbiter.
// The package holds:
//   - the frame-buffer geometry (FB_W x FB_H pixels, PW bits each);
//   - the RAM address width AW;
//   - the write-request record carried through the write FIFO;
//   - the RGB444 black constant;
//   - xy_to_addr(), which maps a pixel coordinate to its linear RAM address.
// -----------------------------------------------------------------------------
package fb_pkg;

  localparam int FB_W = 320;  // frame-buffer width in pixels
  localparam int FB_H = 240;  // frame-buffer height in pixels
  localparam int AW   = 17;   // RAM address width; FB_W*FB_H <= 2**AW
  localparam int PW   = 12;   // pixel width, RGB444

  localparam int XW   = 9;    // decoder write x width
  localparam int YW   = 8;    // decoder write y width

  localparam logic [PW-1:0] RGB_BLACK = '0;

  // One pending decoder write as stored in the write FIFO.
  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [PW-1:0] data;
  } wr_req_t;

  // Linear address y*FB_W + x. For FB_W=320 the multiply is two shifted adds:
  // 320 = 256 + 64. Both operands are widened to AW bits before the shifts so
  // nothing is truncated. The 9-bit y covers v_addr>>1 directly.
  function automatic logic [AW-1:0] xy_to_addr(input logic [8:0] x,
                                               input logic [8:0] y);
    logic [AW-1:0] w_x;
    logic [AW-1:0] w_y;
    w_x = AW'(x);
    w_y = AW'(y);
    return (w_y << 8) + (w_y << 6) + w_x;
  endfunction

endpackage : fb_pkg

// File: rtl/fb_wr_fifo.sv
// -----------------------------------------------------------------------------
// fb_wr_fifo
// Synchronous FIFO of decoder write requests. There is no bypass, so an entry
// pushed on an edge becomes visible at the head only after that edge.
//
// Ports:
//   pclk     in   pixel clock
//   reset    in   asynchronous, active-low reset; empties the FIFO
//   i_push   in   write i_din on this edge (caller guarantees !o_full)
//   i_din    in   request to store
//   i_pop    in   drop the head entry on this edge (caller guarantees !o_empty)
//   o_dout   out  head entry (meaningful only when !o_empty)
//   o_full   out  no free entry
//   o_empty  out  no stored entry
// -----------------------------------------------------------------------------
module fb_wr_fifo
  import fb_pkg::*;
#(
  parameter int DEPTH = 4  // entries, power of two, at least 2
) (
  input  logic    pclk,
  input  logic    reset,
  input  logic    i_push,
  input  wr_req_t i_din,
  input  logic    i_pop,
  output wr_req_t o_dout,
  output logic    o_full,
  output logic    o_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty can be told apart
  // when the index bits are equal.
  logic [PTR_W:0] r_wr_ptr;
  logic [PTR_W:0] r_rd_ptr;
  wr_req_t        r_mem [DEPTH];

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      // NOTE: sequential state is updated with non-blocking assignments so every
      // always_ff sees the pre-edge values of every other register.
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // NOTE: the storage array is deliberately left out of reset; only the
  // pointers define which entries are live, so clearing them empties the FIFO.
  always_ff @(posedge pclk) begin
    if (i_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= i_din;
  end

  assign o_dout  = r_mem[r_rd_ptr[PTR_W-1:0]];
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                   (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);

endmodule : fb_wr_fifo

// File: rtl/fb_arbiter.sv
// -----------------------------------------------------------------------------
// fb_arbiter
// Arbiter for the single-port frame-buffer RAM. It sits between the JPEG
// decoder pixel writer and the 640x480 VGA scan-out. The frame buffer is
// 320x240 (geometry from fb_pkg), and each stored pixel is shown as a 2x2
// block on screen.
//
// Slot choice:
//   - Display slot: valid=1 and h_addr[0]=0. The RAM is read at the scan
//     position, halved in both axes.
//   - Write slot: every other cycle. The FIFO head is written if one exists;
//     otherwise the RAM is idle and ram_addr holds its previous value.
//
// Display path: read at t, data on ram_rdata at t+1, pixel register loaded at
// the end of t+1, vga_data shows the pixel in t+2 and t+3. This is a fixed
// 2-cycle latency.
//
// Ports:
//   pclk       in   25 MHz pixel clock
//   reset      in   asynchronous, active-low reset
//   h_addr     in   scan x 0..639
//   v_addr     in   scan y 0..479
//   valid      in   scan position is visible
//   vga_data   out  pixel to the VGA timing controller; black when not visible
//   wr_valid   in   decoder presents a pixel write
//   wr_ready   out  write FIFO can accept
//   wr_x       in   write x coordinate
//   wr_y       in   write y coordinate
//   wr_data    in   write pixel
//   ram_addr   out  RAM address
//   ram_we     out  RAM write enable
//   ram_wdata  out  RAM write data
//   ram_rdata  in   RAM read data, one cycle after the address
//   drop_err   out  sticky: an out-of-range write was accepted and dropped
// -----------------------------------------------------------------------------
module fb_arbiter
  import fb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4  // write FIFO entries, power of two
) (
  input  logic          pclk,
  input  logic          reset,
  input  logic [9:0]    h_addr,
  input  logic [9:0]    v_addr,
  input  logic          valid,
  output logic [PW-1:0] vga_data,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [XW-1:0] wr_x,
  input  logic [YW-1:0] wr_y,
  input  logic [PW-1:0] wr_data,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [PW-1:0] ram_wdata,
  input  logic [PW-1:0] ram_rdata,
  output logic          drop_err
);

  // ---------------------------------------------------------------------------
  // Write FIFO and acceptance
  // ---------------------------------------------------------------------------
  wr_req_t w_fifo_din;
  wr_req_t w_fifo_head;
  logic    w_fifo_full;
  logic    w_fifo_empty;
  logic    w_accept;
  logic    w_in_range;
  logic    w_push;
  logic    w_pop;

  // wr_ready depends only on the stored count, so a pop in the same cycle does
  // not open a slot early. Gating with reset forces it low while reset is
  // asserted and lets it rise in the first cycle after release.
  assign wr_ready   = reset & ~w_fifo_full;
  assign w_accept   = wr_valid & wr_ready;
  assign w_in_range = (wr_x < XW'(FB_W)) && (wr_y < YW'(FB_H));
  // Out-of-range writes are still accepted so the decoder never stalls on
  // them. They simply never enter the FIFO.
  assign w_push     = w_accept & w_in_range;

  assign w_fifo_din = '{x: wr_x, y: wr_y, data: wr_data};

  fb_wr_fifo #(
    .DEPTH   (FIFO_DEPTH)
  ) u_wr_fifo (
    .pclk    (pclk),
    .reset   (reset),
    .i_push  (w_push),
    .i_din   (w_fifo_din),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // ---------------------------------------------------------------------------
  // Slot decoder and RAM address mux
  // ---------------------------------------------------------------------------
  logic          w_disp_slot;
  logic [AW-1:0] w_disp_addr;
  logic [AW-1:0] w_wr_addr;
  logic [AW-1:0] w_ram_addr;
  logic [AW-1:0] r_ram_addr;
  logic          w_unused;

  // Qualifying with reset keeps ram_addr, ram_we and ram_wdata at their reset
  // values while reset is asserted. The FIFO is also empty then, so no pop
  // can occur.
  assign w_disp_slot = reset & valid & ~h_addr[0];
  assign w_pop       = ~w_disp_slot & ~w_fifo_empty;

  // The 2x2 pixel replication is done by dropping bit 0 of the scan position.
  assign w_disp_addr = xy_to_addr(h_addr[9:1], v_addr[9:1]);
  assign w_wr_addr   = xy_to_addr(w_fifo_head.x, {1'b0, w_fifo_head.y});

  // Bit 0 of the scan row selects the duplicated line and is not needed here.
  assign w_unused    = &{1'b0, v_addr[0]};

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave it unassigned and infer a latch.
    ram_we     = 1'b0;
    ram_wdata  = RGB_BLACK;
    w_ram_addr = r_ram_addr;
    if (w_disp_slot) begin
      w_ram_addr = w_disp_addr;
    end else if (w_pop) begin
      ram_we     = 1'b1;
      ram_wdata  = w_fifo_head.data;
      w_ram_addr = w_wr_addr;
    end
  end

  assign ram_addr = w_ram_addr;

  // ---------------------------------------------------------------------------
  // Display pipeline and sticky error
  // ---------------------------------------------------------------------------
  logic          r_rd_pend;  // a display read was issued last cycle
  logic [1:0]    r_vis;      // valid delayed by one and two cycles
  logic [PW-1:0] r_pix;
  logic          r_drop_err;

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      r_ram_addr <= '0;
      r_rd_pend  <= 1'b0;
      r_vis      <= '0;
      r_pix      <= RGB_BLACK;
      r_drop_err <= 1'b0;
    end else begin
      r_ram_addr <= w_ram_addr;
      r_rd_pend  <= w_disp_slot;
      // The delay line tracks valid itself, not only the read slots. The
      // odd-column cycle after a read is therefore still marked visible, and
      // the held pixel is shown for both horizontal copies.
      r_vis      <= {r_vis[0], valid};
      // Load only on returning display reads. The pixel is then held through
      // the following write slot.
      if (r_rd_pend) r_pix <= ram_rdata;
      if (w_accept && !w_in_range) r_drop_err <= 1'b1;
    end
  end

  assign vga_data = r_vis[1] ? r_pix : RGB_BLACK;
  assign drop_err = r_drop_err;

endmodule : fb_arbiter

// File: tb/tb_fb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fb_arbiter
// Directed bench for fb_arbiter. A behavioural single-port RAM is attached to
// the RAM port. Inputs are driven 1 ns after the rising edge, and outputs are
// sampled a further 1 ns later, inside the same cycle. Expected values are
// hand-computed. The contention phase uses a small queue model of the FIFO.
// -----------------------------------------------------------------------------
module tb_fb_arbiter;

  logic        pclk     = 1'b0;
  logic        reset    = 1'b0;
  logic [9:0]  h_addr   = '0;
  logic [9:0]  v_addr   = '0;
  logic        valid    = 1'b0;
  logic [11:0] vga_data;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [8:0]  wr_x     = '0;
  logic [7:0]  wr_y     = '0;
  logic [11:0] wr_data  = '0;
  logic [16:0] ram_addr;
  logic        ram_we;
  logic [11:0] ram_wdata;
  logic [11:0] ram_rdata;
  logic        drop_err;

  int n_checks = 0;
  int n_errors = 0;
  int n_ram_wr = 0;

  fb_arbiter #(
    .FIFO_DEPTH (4)
  ) dut (
    .pclk      (pclk),
    .reset     (reset),
    .h_addr    (h_addr),
    .v_addr    (v_addr),
    .valid     (valid),
    .vga_data  (vga_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_x      (wr_x),
    .wr_y      (wr_y),
    .wr_data   (wr_data),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .drop_err  (drop_err)
  );

  always #20 pclk = ~pclk;

  // Single-port RAM: synchronous write, registered read, and a write counter.
  logic [11:0] mem [0:(1<<17)-1];
  always @(posedge pclk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
      n_ram_wr      <= n_ram_wr + 1;
    end
    ram_rdata <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  initial begin
    int   n_base;
    int   k;
    logic exp_ready;
    logic saw_full;
    int   exp_q[$];

    // ---- 1. reset, then release ----
    repeat (3) tick();
    check("rst_ready",    32'(wr_ready),  32'd0);
    check("rst_we",       32'(ram_we),    32'd0);
    check("rst_vga",      32'(vga_data),  32'd0);
    check("rst_addr",     32'(ram_addr),  32'd0);
    check("rst_drop",     32'(drop_err),  32'd0);
    reset = 1'b1;
    #1;
    check("rel_ready",    32'(wr_ready),  32'd1);
    check("rel_we",       32'(ram_we),    32'd0);
    check("rel_vga",      32'(vga_data),  32'd0);
    check("rel_drop",     32'(drop_err),  32'd0);

    // ---- 2. blanking burst: x=0..3, y=0, data F00..F03 ----
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) begin
        wr_valid = 1'b1;
        wr_x     = 9'(i);
        wr_y     = 8'd0;
        wr_data  = 12'hF00 + 12'(i);
      end else begin
        wr_valid = 1'b0;
      end
      #1;
      check("burst_ready", 32'(wr_ready), 32'd1);
      if (i > 0) begin
        check("burst_we",    32'(ram_we),    32'd1);
        check("burst_addr",  32'(ram_addr),  32'(i - 1));
        check("burst_wdata", 32'(ram_wdata), 32'(12'hF00 + 12'(i - 1)));
      end
      tick();
    end
    #1;
    check("idle_we",   32'(ram_we),   32'd0);
    check("idle_hold", 32'(ram_addr), 32'd3);

    // ---- 3. preload addr 321 (x=1,y=1) = 0x0A5, then display read ----
    wr_valid = 1'b1; wr_x = 9'd1; wr_y = 8'd1; wr_data = 12'h0A5;
    tick();
    wr_valid = 1'b0;
    #1;
    check("pre_we",    32'(ram_we),    32'd1);
    check("pre_addr",  32'(ram_addr),  32'd321);
    check("pre_wdata", 32'(ram_wdata), 32'h0A5);
    tick();
    valid = 1'b1; h_addr = 10'd2; v_addr = 10'd2;      // cycle t
    #1;
    check("disp_addr", 32'(ram_addr), 32'd321);
    check("disp_we",   32'(ram_we),   32'd0);
    tick();
    h_addr = 10'd3;                                     // t+1
    #1;
    check("odd_we",    32'(ram_we),   32'd0);
    check("odd_hold",  32'(ram_addr), 32'd321);
    check("vga_t1",    32'(vga_data), 32'd0);
    tick();
    valid = 1'b0; h_addr = 10'd0; v_addr = 10'd0;      // t+2
    #1;
    check("vga_t2", 32'(vga_data), 32'h0A5);
    tick();                                             // t+3
    check("vga_t3", 32'(vga_data), 32'h0A5);
    tick();                                             // t+4
    check("vga_t4", 32'(vga_data), 32'd0);

    // ---- 4. contention: 8 writes (x=10+k, y=5) across a visible line ----
    n_base   = n_ram_wr;
    k        = 0;
    saw_full = 1'b0;
    valid    = 1'b1;
    v_addr   = 10'd0;
    for (int c = 0; c < 24; c++) begin
      h_addr = 10'(c);
      if (k < 8) begin
        wr_valid = 1'b1;
        wr_x     = 9'(10 + k);
        wr_y     = 8'd5;
        wr_data  = 12'h100 + 12'(k);
      end else begin
        wr_valid = 1'b0;
      end
      #1;
      exp_ready = (exp_q.size() < 4);
      check("cont_ready", 32'(wr_ready), 32'(exp_ready));
      if (!exp_ready) saw_full = 1'b1;
      if (c % 2 == 0) begin
        check("cont_disp_we",   32'(ram_we),   32'd0);
        check("cont_disp_addr", 32'(ram_addr), 32'(c / 2));
      end else if (exp_q.size() > 0) begin
        check("cont_wr_we",    32'(ram_we),    32'd1);
        check("cont_wr_addr",  32'(ram_addr),  32'(1610 + exp_q[0]));
        check("cont_wr_wdata", 32'(ram_wdata), 32'(12'h100 + 12'(exp_q[0])));
        void'(exp_q.pop_front());
      end else begin
        check("cont_idle_we", 32'(ram_we), 32'd0);
      end
      if (wr_valid && exp_ready) begin
        exp_q.push_back(k);
        k++;
      end
      tick();
    end
    check("cont_saw_full", 32'(saw_full),            32'd1);
    check("cont_accepted", 32'(k),                   32'd8);
    check("cont_n_writes", 32'(n_ram_wr - n_base),   32'd8);

    // ---- 5. range boundary: corner in range, then out-of-range drops ----
    valid = 1'b0; h_addr = 10'd0;
    wr_valid = 1'b1; wr_x = 9'd319; wr_y = 8'd239; wr_data = 12'h3C3;
    tick();
    wr_valid = 1'b0;
    #1;
    check("corner_we",   32'(ram_we),   32'd1);
    check("corner_addr", 32'(ram_addr), 32'd76799);
    check("corner_drop", 32'(drop_err), 32'd0);
    tick();
    n_base = n_ram_wr;
    wr_valid = 1'b1; wr_x = 9'd320; wr_y = 8'd0; wr_data = 12'hABC;
    #1;
    check("oor_x_ready", 32'(wr_ready), 32'd1);
    tick();
    wr_x = 9'd0; wr_y = 8'd240;
    #1;
    check("oor_x_drop", 32'(drop_err), 32'd1);
    check("oor_x_we",   32'(ram_we),   32'd0);
    tick();
    wr_valid = 1'b0;
    #1;
    check("oor_y_we",   32'(ram_we),   32'd0);
    repeat (3) tick();
    check("oor_sticky",  32'(drop_err),          32'd1);
    check("oor_n_write", 32'(n_ram_wr - n_base), 32'd0);

    // ---- 6. reset with 3 writes queued mid-line ----
    valid = 1'b1; h_addr = 10'd20; v_addr = 10'd10;     // reads addr 1610
    wr_valid = 1'b1; wr_x = 9'd0; wr_y = 8'd100; wr_data = 12'hEE0;
    #1;
    check("mid_addr", 32'(ram_addr), 32'd1610);
    check("mid_we",   32'(ram_we),   32'd0);
    tick();
    wr_x = 9'd1; wr_data = 12'hEE1;
    tick();
    wr_x = 9'd2; wr_data = 12'hEE2;
    #1;
    check("mid_vga_a", 32'(vga_data), 32'h100);
    tick();
    wr_valid = 1'b0;
    #1;
    check("mid_vga_b", 32'(vga_data), 32'h100);
    check("mid_drop",  32'(drop_err), 32'd1);
    check("mid_ready", 32'(wr_ready), 32'd1);
    reset = 1'b0;
    #1;
    check("arst_vga",   32'(vga_data), 32'd0);
    check("arst_drop",  32'(drop_err), 32'd0);
    check("arst_we",    32'(ram_we),   32'd0);
    check("arst_addr",  32'(ram_addr), 32'd0);
    check("arst_ready", 32'(wr_ready), 32'd0);
    n_base = n_ram_wr;
    tick();
    tick();
    valid = 1'b0;
    reset = 1'b1;
    #1;
    check("rel2_ready", 32'(wr_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      #1;
      check("rel2_we", 32'(ram_we), 32'd0);
      tick();
    end
    check("rel2_n_writes", 32'(n_ram_wr - n_base), 32'd0);
    check("rel2_drop",     32'(drop_err),          32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_fb_arbiter
